fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch initiator that drives the instruction memory's word-addressed read port.
- Holds the program counter and presents Address every cycle. Captures the combinationally returned Instruction into a 2-entry prefetch buffer.
- Delivers {instruction, PC} to the decode stage over a valid/ready handshake.
- Accepts branch/jump redirects from later stages, which flush the buffer.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- Clk  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous active-low reset.
- Address  output  32  fetch address to instruction memory; always equals PC.
- Instruction  input  32  memory read data for Address, valid in the same cycle (combinational memory).
- FetchValid  output  1  buffer head holds a valid instruction.
- FetchInstr  output  32  instruction at buffer head.
- FetchPC  output  32  address of FetchInstr.
- DecodeReady  input  1  decode accepts the head this cycle.
- RedirectValid  input  1  one-cycle redirect request.
- RedirectTarget  input  32  new PC; bits [1:0] ignored and forced to 0.
- FetchCount  output  32  number of instructions delivered (handshakes completed).

Behaviour:
- Clock and reset:
  - One clock, Clk.
  - Reset_n is asynchronous and active-low.
  - In reset: PC=RESET_PC, buffer count=0, rd/wr pointers=0, FetchCount=0.
  - Outputs in reset: FetchValid=0, FetchInstr=0, FetchPC=0, Address=RESET_PC.
- Buffer:
  - 2-entry circular FIFO of {instr[31:0], pc[31:0]}, 1-bit pointers, 2-bit count (0..2).
  - FetchInstr/FetchPC come from the head entry and are registered storage (no combinational path from Instruction).
  - FetchInstr/FetchPC are don't-care when count=0.
- Handshake:
  - pop = FetchValid & DecodeReady.
  - FetchValid = (count!=0) & ~RedirectValid; the wrong-path head is never delivered in a redirect cycle.
  - Outputs hold stable while FetchValid=1 and DecodeReady=0.
- Fetch/push:
  - push = ~RedirectValid & (count<2 | pop).
  - On push: entry[wr] <= {Instruction, PC}; wr++; PC <= PC+4, 32-bit wrap (32'hFFFF_FFFC -> 0).
  - Without push, PC holds.
- Count update: count += push - pop. Simultaneous push and pop with count=2 stays at 2; with count=1 stays at 1.
- Redirect (highest priority):
  - count<=0, rd<=wr<=0, PC<={RedirectTarget[31:2],2'b00}.
  - No push and no pop that cycle; DecodeReady is ignored.
  - FetchValid rises 1 cycle after the redirect edge, giving a 2-cycle bubble from the redirect assertion cycle.
- Latency:
  - The first instruction is visible on FetchValid in the first cycle after the first rising edge following Reset_n deassertion.
  - Steady-state throughput with DecodeReady=1: 1 instruction/cycle.
- FetchCount: increments by 1 on each pop and wraps at 2^32. It is not cleared by redirect.
- Mid-operation reset: asserting Reset_n=0 at any time immediately clears all state and outputs as above, without waiting for a clock edge.
- Misalignment: PC is never misaligned; RESET_PC[1:0] must be 0 by constraint.

Test Plan:
- Reset with RESET_PC=0, memory words 0..3 = 0x11,0x22,0x33,0x44, DecodeReady=1 -> FetchValid rises the cycle after the first edge; FetchInstr/FetchPC sequence (0x11,0),(0x22,4),(0x33,8),(0x44,C) on consecutive cycles; FetchCount=4.
- DecodeReady=0 for 5 cycles from reset -> buffer fills to 2 and PC stops at 0x8; FetchInstr stays 0x11. Release DecodeReady -> 0x11,0x22,0x33 delivered back-to-back with no loss or duplicate.
- RedirectValid=1 with RedirectTarget=0x103 while count=2 -> FetchValid=0 in that cycle and next; Address=0x100 on the next cycle; the following instruction delivered has FetchPC=0x100; FetchCount unchanged by the flush.
- Redirect in the same cycle as DecodeReady=1 with count=1 -> no pop (FetchCount unchanged) and buffer empties.
- RESET_PC=32'hFFFF_FFF8 -> FetchPC sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Reset_n pulsed low mid-cycle while count=2 -> FetchValid=0, FetchCount=0 and Address=RESET_PC immediately, before the next edge.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch: drives PC to a combinational imem and buffers {instr, pc} in a 2-entry FIFO for decode.
// Latency: an instruction fetched on an edge is offered on FetchValid in the cycle after; 1 instr/cycle steady state.
// Backpressure: DecodeReady low holds the head; fetch stalls (PC holds) once both entries are full.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset_n,
    output logic [31:0] Address,
    input  logic [31:0] Instruction,
    output logic        FetchValid,
    output logic [31:0] FetchInstr,
    output logic [31:0] FetchPC,
    input  logic        DecodeReady,
    input  logic        RedirectValid,
    input  logic [31:0] RedirectTarget,
    output logic [31:0] FetchCount
);

    logic [31:0] pc;
    logic [1:0]  cnt;
    logic        rd_ptr;
    logic        wr_ptr;
    logic [31:0] buf_instr [2];
    logic [31:0] buf_pc    [2];
    logic [31:0] fetch_cnt;
    logic        pop;
    logic        push;

    // A redirect masks the head so a wrong-path instruction is never handed to decode.
    assign FetchValid = (cnt != 2'd0) & ~RedirectValid;
    assign pop        = FetchValid & DecodeReady;
    assign push       = ~RedirectValid & ((cnt < 2'd2) | pop);

    assign Address    = pc;
    assign FetchInstr = buf_instr[rd_ptr];
    assign FetchPC    = buf_pc[rd_ptr];
    assign FetchCount = fetch_cnt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pc        <= RESET_PC;
            cnt       <= 2'd0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            fetch_cnt <= 32'd0;
            for (int i = 0; i < 2; i++) begin
                buf_instr[i] <= 32'd0;
                buf_pc[i]    <= 32'd0;
            end
        end else if (RedirectValid) begin
            cnt    <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            pc     <= {RedirectTarget[31:2], 2'b00};
        end else begin
            if (push) begin
                buf_instr[wr_ptr] <= Instruction;
                buf_pc[wr_ptr]    <= pc;
                wr_ptr            <= ~wr_ptr;
                pc                <= pc + 32'd4;
            end
            if (pop) begin
                rd_ptr    <= ~rd_ptr;
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule
